// File: rtl/engine_timer_slave_if.sv
// Engine data/instruction bus as seen by a memory-mapped responder.
// The responder stalls the engine with waitrequest until the access completes.
interface engine_timer_slave_if #(
  parameter int WIDTHA = 3,
  parameter int WIDTHD = 32
);
  logic              chipselect;
  logic [WIDTHA-1:0] address;
  logic              read;
  logic              write;
  logic [WIDTHD-1:0] writedata;
  logic [WIDTHD-1:0] readdata;
  logic              waitrequest;

  modport master (
    output chipselect, address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  chipselect, address, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/engine_timer_slave.sv
// Bus responder with wait states, a down-counting interval timer and software interrupts.
// Define ENGINE_TIMER_SWIRQ_EN to build the SWIRQ pending register behind addresses 4/5.
module engine_timer_slave #(
  parameter int WIDTHA      = 3,
  parameter int WIDTHD      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clock,
  input  logic                 clock_areset_n,
  engine_timer_slave_if.slave  bus,
  output logic [WIDTHD-1:0]    irq
);

  localparam logic [3:0]        WS  = 4'(WAIT_STATES);
  localparam logic [WIDTHD-1:0] ONE = WIDTHD'(1);

  localparam logic [WIDTHA-1:0] A_CTRL   = WIDTHA'(0);
  localparam logic [WIDTHA-1:0] A_LOAD   = WIDTHA'(1);
  localparam logic [WIDTHA-1:0] A_COUNT  = WIDTHA'(2);
  localparam logic [WIDTHA-1:0] A_STATUS = WIDTHA'(3);
  localparam logic [WIDTHA-1:0] A_SWSET  = WIDTHA'(4);
  localparam logic [WIDTHA-1:0] A_SWCLR  = WIDTHA'(5);

  logic [3:0]        wait_cnt;
  logic              acc;
  logic              stall;
  logic              wr_en;

  logic              ctrl_en, ctrl_reload, ctrl_irqen;
  logic              en_nxt, reload_nxt, irqen_nxt;
  logic [WIDTHD-1:0] load, load_nxt;
  logic [WIDTHD-1:0] count, count_nxt;
  logic              exp_flag, exp_nxt;
  logic [WIDTHD-1:0] pending, pending_nxt;
  logic [WIDTHD-1:0] rd_mux;
  logic [WIDTHD-1:0] irq_nxt;

  assign acc             = bus.chipselect & (bus.read | bus.write);
  assign stall           = acc & (wait_cnt != WS);
  assign bus.waitrequest = stall;
  // A write strobe wins when both strobes are high.
  assign wr_en           = acc & ~stall & bus.write;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      A_CTRL:   rd_mux = {{(WIDTHD-3){1'b0}}, ctrl_irqen, ctrl_reload, ctrl_en};
      A_LOAD:   rd_mux = load;
      A_COUNT:  rd_mux = count;
      A_STATUS: rd_mux = {{(WIDTHD-1){1'b0}}, exp_flag};
      A_SWSET:  rd_mux = pending;
      A_SWCLR:  rd_mux = pending;
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    en_nxt     = ctrl_en;
    reload_nxt = ctrl_reload;
    irqen_nxt  = ctrl_irqen;
    load_nxt   = load;
    count_nxt  = count;
    exp_nxt    = exp_flag;

    if (ctrl_en) begin
      if (count != '0) begin
        count_nxt = count - ONE;
      end else if (ctrl_reload) begin
        count_nxt = load;
      end else begin
        en_nxt = 1'b0;
      end
    end

    // Bus writes override the timer's own update; the hardware EXP set overrides a clear.
    if (wr_en) begin
      case (bus.address)
        A_CTRL:   {irqen_nxt, reload_nxt, en_nxt} = bus.writedata[2:0];
        A_LOAD:   load_nxt = bus.writedata;
        A_COUNT:  count_nxt = bus.writedata;
        A_STATUS: if (bus.writedata[0]) exp_nxt = 1'b0;
        default:  ;
      endcase
    end

    if (ctrl_en && (count == '0)) begin
      exp_nxt = 1'b1;
    end
  end

`ifdef ENGINE_TIMER_SWIRQ_EN
  always_comb begin
    pending_nxt = pending;
    if (wr_en && (bus.address == A_SWSET)) begin
      pending_nxt = pending | bus.writedata;
    end else if (wr_en && (bus.address == A_SWCLR)) begin
      pending_nxt = pending & ~bus.writedata;
    end
  end

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end
`else
  assign pending     = '0;
  assign pending_nxt = '0;
`endif

  assign irq_nxt = {pending_nxt[WIDTHD-1:1], pending_nxt[0] | (exp_nxt & irqen_nxt)};

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      wait_cnt     <= '0;
      bus.readdata <= '0;
      irq          <= '0;
      ctrl_en      <= 1'b0;
      ctrl_reload  <= 1'b0;
      ctrl_irqen   <= 1'b0;
      load         <= '0;
      count        <= '0;
      exp_flag     <= 1'b0;
    end else begin
      wait_cnt <= stall ? (wait_cnt + 4'd1) : 4'd0;
      if (acc) begin
        bus.readdata <= rd_mux;
      end
      irq         <= irq_nxt;
      ctrl_en     <= en_nxt;
      ctrl_reload <= reload_nxt;
      ctrl_irqen  <= irqen_nxt;
      load        <= load_nxt;
      count       <= count_nxt;
      exp_flag    <= exp_nxt;
    end
  end

endmodule

// File: tb/tb_engine_timer_slave.sv
// Bench for engine_timer_slave with WAIT_STATES=2: a cycle model checked every cycle,
// plus directed accesses with literal expectations.
module tb_engine_timer_slave;

  localparam int WS = 2;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq;

  int checks = 0;
  int passed = 0;

  engine_timer_slave_if #(.WIDTHA(3), .WIDTHD(32)) bus ();

  engine_timer_slave #(.WIDTHA(3), .WIDTHD(32), .WAIT_STATES(WS)) dut (
    .clock          (clock),
    .clock_areset_n (rst_n),
    .bus            (bus),
    .irq            (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0]  m_ctrl  = '0;
  logic [31:0] m_load  = '0;
  logic [31:0] m_count = '0;
  logic        m_exp   = 1'b0;
  logic [31:0] m_pend  = '0;
  logic [31:0] m_rd    = '0;
  logic [31:0] m_irq   = '0;
  int          m_age   = 0;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {29'd0, m_ctrl};
      3'd1: return m_load;
      3'd2: return m_count;
      3'd3: return {31'd0, m_exp};
      3'd4, 3'd5: return m_pend;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_ctrl = '0; m_load = '0; m_count = '0; m_exp = 1'b0;
      m_pend = '0; m_rd = '0; m_irq = '0; m_age = 0;
    end else begin
      logic        acc, done, wr;
      logic [2:0]  n_ctrl;
      logic [31:0] n_load, n_count, n_pend;
      logic        n_exp;
      acc  = bus.chipselect && (bus.read || bus.write);
      done = acc && (m_age == WS);
      wr   = done && bus.write;
      if (acc) m_rd = model_read(bus.address);
      n_ctrl = m_ctrl; n_load = m_load; n_count = m_count; n_exp = m_exp; n_pend = m_pend;
      if (m_ctrl[0]) begin
        if (m_count > 0) n_count = m_count - 1;
        else if (m_ctrl[1]) n_count = m_load;
        else n_ctrl[0] = 1'b0;
      end
      if (wr) begin
        case (bus.address)
          3'd0: n_ctrl = bus.writedata[2:0];
          3'd1: n_load = bus.writedata;
          3'd2: n_count = bus.writedata;
          3'd3: if (bus.writedata[0]) n_exp = 1'b0;
`ifdef ENGINE_TIMER_SWIRQ_EN
          3'd4: n_pend = m_pend | bus.writedata;
          3'd5: n_pend = m_pend & ~bus.writedata;
`endif
          default: ;
        endcase
      end
      if (m_ctrl[0] && m_count == 0) n_exp = 1'b1;
      m_age   = (acc && !done) ? m_age + 1 : 0;
      m_ctrl  = n_ctrl; m_load = n_load; m_count = n_count; m_exp = n_exp; m_pend = n_pend;
      m_irq   = {m_pend[31:1], m_pend[0] | (m_exp & m_ctrl[2])};
    end
  end

  always @(negedge clock) begin
    chk("cmp_waitrequest", {31'd0, bus.waitrequest},
        {31'd0, (bus.chipselect && (bus.read || bus.write) && m_age != WS)});
    chk("cmp_irq", irq, m_irq);
    chk("cmp_readdata", bus.readdata, m_rd);
  end

  // ---------------- stimulus ----------------
  task automatic bus_xfer(input bit r, input bit w, input logic [2:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int stalls);
    bit ok;
    ok = 1'b0; stalls = 0; rd = '0;
    @(posedge clock); #1;
    bus.chipselect = 1'b1; bus.read = r; bus.write = w; bus.address = a; bus.writedata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!bus.waitrequest) begin
        ok = 1'b1; rd = bus.readdata;
        break;
      end
      stalls++;
    end
    if (!ok) chk("bus_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] rd; int st;
    bus_xfer(1'b0, 1'b1, a, d, rd, st);
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] rd);
    int st;
    bus_xfer(1'b1, 1'b0, a, 32'd0, rd, st);
  endtask

  task automatic wait_irq0(output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (irq[0]) begin n = i; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] swirq_exp1, swirq_exp2;
    int st, n;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = '0; bus.writedata = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_readdata", bus.readdata, 32'd0);
    chk("reset_irq", irq, 32'd0);
    chk("reset_waitrequest", {31'd0, bus.waitrequest}, 32'd0);
    @(posedge clock); #3 rst_n = 1'b1;

    // Wait states and readback
    bus_xfer(1'b0, 1'b1, 3'd1, 32'h1234, rd, st);
    chk("load_wr_stalls", st, 32'd2);
    bus_xfer(1'b1, 1'b0, 3'd1, 32'd0, rd, st);
    chk("load_rd_stalls", st, 32'd2);
    chk("load_rd_data", rd, 32'h0000_1234);

    // Auto-reload: first expiry five cycles after the CTRL write completes
    bus_wr(3'd1, 32'd3);
    bus_wr(3'd2, 32'd3);
    bus_wr(3'd0, 32'h7);
    wait_irq0(n);
    chk("autoreload_first_exp", n, 32'd5);

    // STATUS clear completing in the COUNT==0 cycle loses to the expiry
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (m_count == 3) break;
    end
    bus_wr(3'd3, 32'd1);
    @(negedge clock);
    chk("collide_irq0", {31'd0, irq[0]}, 32'd1);
    bus_wr(3'd0, 32'd0);
    bus_rd(3'd3, rd);
    chk("collide_status", rd, 32'd1);
    bus_wr(3'd3, 32'd1);

    // One-shot
    bus_wr(3'd2, 32'd2);
    bus_wr(3'd0, 32'h5);
    wait_irq0(n);
    chk("oneshot_exp_delay", n, 32'd4);
    bus_rd(3'd0, rd);
    chk("oneshot_ctrl", rd, 32'h4);
    bus_rd(3'd2, rd);
    chk("oneshot_count", rd, 32'd0);
    bus_rd(3'd3, rd);
    chk("oneshot_status", rd, 32'd1);
    bus_wr(3'd3, 32'd1);
    @(negedge clock);
    chk("status_clear_irq", irq, 32'd0);

    // Software interrupts
`ifdef ENGINE_TIMER_SWIRQ_EN
    swirq_exp1 = 32'h8000_0001; swirq_exp2 = 32'h8000_0000;
`else
    swirq_exp1 = 32'd0; swirq_exp2 = 32'd0;
`endif
    bus_wr(3'd4, 32'h8000_0001);
    @(negedge clock);
    chk("swirq_set_irq", irq, swirq_exp1);
    bus_wr(3'd5, 32'h1);
    @(negedge clock);
    chk("swirq_clr_irq", irq, swirq_exp2);
    bus_rd(3'd5, rd);
    chk("swirq_rd", rd, swirq_exp2);
    bus_wr(3'd5, 32'h8000_0000);

    // Unmapped address
    bus_xfer(1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF, rd, st);
    chk("unmapped_wr_stalls", st, 32'd2);
    bus_xfer(1'b1, 1'b0, 3'd7, 32'd0, rd, st);
    chk("unmapped_rd", rd, 32'd0);

    // Aborted access followed by a full one; both strobes behave as a write
    @(posedge clock); #1;
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 3'd1;
    @(posedge clock); #1;
    bus.chipselect = 1'b0; bus.read = 1'b0;
    bus_xfer(1'b1, 1'b1, 3'd1, 32'h55, rd, st);
    chk("both_strobe_stalls", st, 32'd2);
    bus_rd(3'd1, rd);
    chk("both_strobe_load", rd, 32'h55);

    // Reset in the middle of a stalled read
    bus_wr(3'd2, 32'd9);
    @(posedge clock); #1;
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 3'd1;
    @(negedge clock);
    @(posedge clock); #3 rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #3 rst_n = 1'b1;
    st = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!bus.waitrequest) begin st = i; rd = bus.readdata; break; end
    end
    chk("rst_read_stalls", st, 32'd2);
    chk("rst_read_data", rd, 32'd0);
    @(posedge clock); #1;
    bus.chipselect = 1'b0; bus.read = 1'b0;
    bus_rd(3'd2, rd);
    chk("rst_count", rd, 32'd0);
    bus_rd(3'd0, rd);
    chk("rst_ctrl", rd, 32'd0);
    @(negedge clock);
    chk("rst_irq", irq, 32'd0);

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
